// File: rtl/mem_server_sram.sv
// Responder end of MemIntf: word-addressed SRAM, fixed-latency pipeline, in-order
// response FIFO with credit backpressure. Optional random response stalls: MEM_SERVER_RAND_STALL_EN.
module mem_server_sram #(
  parameter int          p_opaq_bits  = 8,
  parameter int          p_mem_words  = 1024,
  parameter int          p_latency    = 2,
  parameter int          p_fifo_depth = 4,
  parameter logic [7:0]  p_lfsr_seed  = 8'hA5
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   req_val,
  output logic                   req_rdy,
  input  logic                   req_op,
  input  logic [31:0]            req_addr,
  input  logic [31:0]            req_wdata,
  input  logic [3:0]             req_strb,
  input  logic [p_opaq_bits-1:0] req_opaq,
  output logic                   resp_val,
  input  logic                   resp_rdy,
  output logic                   resp_op,
  output logic [p_opaq_bits-1:0] resp_opaq,
  output logic [31:0]            resp_data
);
  localparam int AW = $clog2(p_mem_words);
  localparam int PW = (p_fifo_depth > 1) ? $clog2(p_fifo_depth) : 1;
  localparam int CW = $clog2(p_fifo_depth + 1);

  typedef struct packed {
    logic                   op;
    logic [p_opaq_bits-1:0] opaq;
    logic [31:0]            data;
  } resp_t;

  logic [31:0]   mem_q [p_mem_words];
  logic          accept, push, pop, empty;
  logic [AW-1:0] widx;
  resp_t         acc_ent, push_ent, head;
  resp_t         fifo_q [p_fifo_depth];
  logic [PW-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
  logic [CW-1:0] occ_q, occ_d, cred_q, cred_d;
  logic          unused_addr;

  assign unused_addr = ^{req_addr[31:AW+2], req_addr[1:0]};

  // Credits cover pipeline + FIFO, so req_rdy depends on registered state only.
  assign req_rdy = (cred_q < CW'(p_fifo_depth));
  assign accept  = req_val & req_rdy;
  assign widx    = req_addr[AW+1:2];
  assign pop     = resp_val & resp_rdy;
  assign empty   = (occ_q == '0);

  always_comb begin
    acc_ent      = '0;
    acc_ent.op   = req_op;
    acc_ent.opaq = req_opaq;
    acc_ent.data = req_op ? 32'd0 : mem_q[widx];
  end

  // SRAM is intentionally not reset; contents survive rst_n.
  always_ff @(posedge clk) begin
    if (accept && req_op) begin
      for (int b = 0; b < 4; b++)
        if (req_strb[b]) mem_q[widx][8*b +: 8] <= req_wdata[8*b +: 8];
    end
  end

  // The FIFO write itself is the last of the p_latency register stages.
  generate
    if (p_latency == 1) begin : g_nopipe
      assign push     = accept;
      assign push_ent = acc_ent;
    end else begin : g_pipe
      localparam int NS = p_latency - 1;
      logic [NS-1:0] vld_q, vld_d;
      resp_t         ent_q [NS];
      resp_t         ent_d [NS];

      always_comb begin
        vld_d[0] = accept;
        ent_d[0] = acc_ent;
        for (int i = 1; i < NS; i++) begin
          vld_d[i] = vld_q[i-1];
          ent_d[i] = ent_q[i-1];
        end
      end

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          vld_q <= '0;
          for (int i = 0; i < NS; i++) ent_q[i] <= '0;
        end else begin
          vld_q <= vld_d;
          for (int i = 0; i < NS; i++) ent_q[i] <= ent_d[i];
        end
      end

      assign push     = vld_q[NS-1];
      assign push_ent = ent_q[NS-1];
    end
  endgenerate

  always_comb begin
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    if (push) wptr_d = (wptr_q == PW'(p_fifo_depth - 1)) ? '0 : wptr_q + PW'(1);
    if (pop)  rptr_d = (rptr_q == PW'(p_fifo_depth - 1)) ? '0 : rptr_q + PW'(1);
    occ_d  = occ_q + CW'(push) - CW'(pop);
    cred_d = cred_q + CW'(accept) - CW'(pop);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q <= '0;
      rptr_q <= '0;
      occ_q  <= '0;
      cred_q <= '0;
      for (int i = 0; i < p_fifo_depth; i++) fifo_q[i] <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      occ_q  <= occ_d;
      cred_q <= cred_d;
      if (push) fifo_q[wptr_q] <= push_ent;
    end
  end

  assign head      = fifo_q[rptr_q];
  assign resp_op   = resp_val & head.op;
  assign resp_opaq = resp_val ? head.opaq : '0;
  assign resp_data = resp_val ? head.data : '0;

`ifdef MEM_SERVER_RAND_STALL_EN
  logic [7:0] lfsr_q, lfsr_d;
  logic       hold_q, hold_d;

  // hold_q keeps an offered response up until taken, so the stall gate never retracts it.
  always_comb begin
    lfsr_d = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
    hold_d = resp_val & ~resp_rdy;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lfsr_q <= p_lfsr_seed;
      hold_q <= 1'b0;
    end else begin
      lfsr_q <= lfsr_d;
      hold_q <= hold_d;
    end
  end

  assign resp_val = ~empty & (hold_q | (lfsr_q[1:0] != 2'b00));
`else
  assign resp_val = ~empty;
`endif

`ifndef SYNTHESIS
  always_ff @(posedge clk) begin
    if (rst_n) begin
      assert (cred_q <= CW'(p_fifo_depth)) else $error("credit count above depth: %0d", cred_q);
      assert (!(push && occ_q == CW'(p_fifo_depth))) else $error("push into full response fifo");
    end
  end
`endif
endmodule

// File: tb/tb_mem_server_sram.sv
// Directed bench for mem_server_sram (default build: latency 2, depth 4, no stalls).
module tb_mem_server_sram;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_val, req_rdy, req_op;
  logic [31:0] req_addr, req_wdata;
  logic [3:0]  req_strb;
  logic [7:0]  req_opaq;
  logic        resp_val, resp_rdy, resp_op;
  logic [7:0]  resp_opaq;
  logic [31:0] resp_data;

  int vecs = 0;
  int errs = 0;

  always #5 clk = ~clk;

  mem_server_sram dut (
    .clk(clk), .rst_n(rst_n),
    .req_val(req_val), .req_rdy(req_rdy), .req_op(req_op), .req_addr(req_addr),
    .req_wdata(req_wdata), .req_strb(req_strb), .req_opaq(req_opaq),
    .resp_val(resp_val), .resp_rdy(resp_rdy), .resp_op(resp_op),
    .resp_opaq(resp_opaq), .resp_data(resp_data)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vecs++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic op, input logic [31:0] a, input logic [31:0] d,
                      input logic [3:0] s, input logic [7:0] o);
    int n = 0;
    req_op = op; req_addr = a; req_wdata = d; req_strb = s; req_opaq = o;
    req_val = 1'b1;
    while (!req_rdy && n < 20) begin tick(); n++; end
    check("send_rdy", {31'd0, req_rdy}, 32'd1);
    tick();
    req_val = 1'b0;
  endtask

  task automatic get_resp(input string tag, input logic op, input logic [7:0] o,
                          input logic [31:0] d);
    int n = 0;
    while (!resp_val && n < 20) begin tick(); n++; end
    check({tag, "_val"},  {31'd0, resp_val}, 32'd1);
    check({tag, "_op"},   {31'd0, resp_op},  {31'd0, op});
    check({tag, "_opaq"}, {24'd0, resp_opaq}, {24'd0, o});
    check({tag, "_data"}, resp_data, d);
    resp_rdy = 1'b1;
    tick();
    resp_rdy = 1'b0;
  endtask

  initial begin
    int acc;
    logic seen;
    rst_n = 1'b0; req_val = 1'b0; req_op = 1'b0; req_addr = '0; req_wdata = '0;
    req_strb = '0; req_opaq = '0; resp_rdy = 1'b0;
    #12;
    check("rst_resp_val",  {31'd0, resp_val}, 32'd0);
    check("rst_resp_op",   {31'd0, resp_op},  32'd0);
    check("rst_resp_opaq", {24'd0, resp_opaq}, 32'd0);
    check("rst_resp_data", resp_data, 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    tick();
    check("rst_req_rdy", {31'd0, req_rdy}, 32'd1);

    // full-word write then read back
    send(1'b1, 32'h100, 32'hDEADBEEF, 4'hF, 8'h01);
    send(1'b0, 32'h100, 32'h0, 4'h0, 8'h3C);
    get_resp("wr_resp", 1'b1, 8'h01, 32'h0);
    get_resp("rd_full", 1'b0, 8'h3C, 32'hDEADBEEF);

    // byte-strobe merge
    send(1'b1, 32'h200, 32'h11223344, 4'hF, 8'h02);
    send(1'b1, 32'h200, 32'hAABBCCDD, 4'b0101, 8'h03);
    send(1'b0, 32'h200, 32'h0, 4'h0, 8'h04);
    get_resp("wr_a", 1'b1, 8'h02, 32'h0);
    get_resp("wr_b", 1'b1, 8'h03, 32'h0);
    get_resp("rd_strb", 1'b0, 8'h04, 32'h11BB33DD);

    // address wrap modulo 1024 words
    send(1'b1, 32'h1000_0004, 32'hCAFEF00D, 4'hF, 8'h05);
    send(1'b0, 32'h0000_0004, 32'h0, 4'h0, 8'h06);
    send(1'b0, 32'h0000_1004, 32'h0, 4'h0, 8'h07);
    get_resp("wr_wrap", 1'b1, 8'h05, 32'h0);
    get_resp("rd_wrap", 1'b0, 8'h06, 32'hCAFEF00D);
    get_resp("rd_wrap2", 1'b0, 8'h07, 32'hCAFEF00D);

    // back-to-back reads: latency 2, one response per cycle
    resp_rdy = 1'b1;
    req_op = 1'b0; req_strb = 4'h0; req_val = 1'b1;
    req_addr = 32'h100; req_opaq = 8'h41;
    check("b2b_rdy", {31'd0, req_rdy}, 32'd1);
    tick();
    check("b2b_lat1_val", {31'd0, resp_val}, 32'd0);
    req_addr = 32'h200; req_opaq = 8'h42;
    tick();
    check("b2b_lat2_val", {31'd0, resp_val}, 32'd1);
    check("b2b_r0_data", resp_data, 32'hDEADBEEF);
    check("b2b_r0_opaq", {24'd0, resp_opaq}, 32'h41);
    req_addr = 32'h4; req_opaq = 8'h43;
    tick();
    req_val = 1'b0;
    check("b2b_r1_val", {31'd0, resp_val}, 32'd1);
    check("b2b_r1_data", resp_data, 32'h11BB33DD);
    tick();
    check("b2b_r2_val", {31'd0, resp_val}, 32'd1);
    check("b2b_r2_data", resp_data, 32'hCAFEF00D);
    tick();
    check("b2b_drained", {31'd0, resp_val}, 32'd0);
    resp_rdy = 1'b0;

    // credit backpressure with resp_rdy held low
    req_op = 1'b0; req_addr = 32'h100; req_val = 1'b1;
    acc = 0;
    for (int i = 0; i < 8; i++) begin
      req_opaq = 8'h10 + 8'(acc);
      if (req_rdy) acc++;
      tick();
    end
    check("bp_accepted", acc, 32'd4);
    check("bp_rdy_low", {31'd0, req_rdy}, 32'd0);
    check("bp_head_val", {31'd0, resp_val}, 32'd1);
    check("bp_head_opaq", {24'd0, resp_opaq}, 32'h10);
    check("bp_hold_data", resp_data, 32'hDEADBEEF);
    resp_rdy = 1'b1;
    tick();
    resp_rdy = 1'b0;
    check("bp_rdy_after_pop", {31'd0, req_rdy}, 32'd1);
    check("bp_next_opaq", {24'd0, resp_opaq}, 32'h11);
    tick();
    req_val = 1'b0;
    get_resp("bp_r1", 1'b0, 8'h11, 32'hDEADBEEF);
    get_resp("bp_r2", 1'b0, 8'h12, 32'hDEADBEEF);
    get_resp("bp_r3", 1'b0, 8'h13, 32'hDEADBEEF);
    get_resp("bp_r4", 1'b0, 8'h14, 32'hDEADBEEF);

    // async reset with three responses queued
    send(1'b1, 32'h300, 32'h55AA55AA, 4'hF, 8'h20);
    send(1'b0, 32'h100, 32'h0, 4'h0, 8'h21);
    send(1'b0, 32'h200, 32'h0, 4'h0, 8'h22);
    repeat (4) tick();
    check("mid_queued_val", {31'd0, resp_val}, 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("mid_async_val", {31'd0, resp_val}, 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    check("mid_rel_val", {31'd0, resp_val}, 32'd0);
    check("mid_rel_rdy", {31'd0, req_rdy}, 32'd1);
    resp_rdy = 1'b1;
    seen = 1'b0;
    repeat (10) begin
      tick();
      if (resp_val) seen = 1'b1;
    end
    check("mid_no_stale", {31'd0, seen}, 32'd0);
    resp_rdy = 1'b0;
    send(1'b0, 32'h300, 32'h0, 4'h0, 8'h30);
    get_resp("mid_mem_kept", 1'b0, 8'h30, 32'h55AA55AA);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
